jt10_adpcm_seq: RTL

- Parametrised, time-multiplexed ADPCM address sequencer for CH channels.
- One channel slot is serviced per `cen`, in round-robin order.
- Each active channel walks a nibble address from its start block to its end block and drives one ROM request per slot visit.
- Optional per-channel loop mode and end-of-sample flags.
- Sits between the CPU register interface and the ADPCM ROM fetch/decoder; the decoder uses `clr` to reset its predictor state.

---
 rtl/jt10_adpcm_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/jt10_adpcm_seq.sv
// Round-robin ADPCM nibble address sequencer.
// One channel slot is serviced per cen; outputs are registered.
module jt10_adpcm_seq #(
    parameter int CH    = 6,
    parameter int CHW   = 3,
    parameter int SW    = 16,
    parameter int SHIFT = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cen,
    input  logic [CHW-1:0]        wr_ch,
    input  logic                  wr_start,
    input  logic                  wr_end,
    input  logic                  wr_loop,
    input  logic [SW-1:0]         wr_data,
    input  logic [CH-1:0]         key_on,
    input  logic [CH-1:0]         key_off,
    output logic [CHW-1:0]        slot,
    output logic [SW+SHIFT-2:0]   addr_out,
    output logic                  sel,
    output logic                  rd,
    output logic                  clr,
    output logic [CH-1:0]         busy,
    output logic [CH-1:0]         flags,
    input  logic [CH-1:0]         clr_flags
);
    localparam int NA = SW + SHIFT;

    logic [SW-1:0]    start_q [CH];
    logic [SW-1:0]    start_d [CH];
    logic [SW-1:0]    end_q   [CH];
    logic [SW-1:0]    end_d   [CH];
    logic [NA-1:0]    addr_q  [CH];
    logic [NA-1:0]    addr_d  [CH];
    logic [CH-1:0]    loop_q, loop_d;
    logic [CH-1:0]    pend_on_q, pend_on_d;
    logic [CH-1:0]    pend_off_q, pend_off_d;
    logic [CH-1:0]    busy_q, busy_d;
    logic [CH-1:0]    flags_q, flags_d;
    logic [CH-1:0]    reload_q, reload_d;
    logic [CHW-1:0]   s_q, s_d;
    logic [CHW-1:0]   slot_q, slot_d;
    logic [NA-2:0]    addr_out_q, addr_out_d;
    logic             sel_q, sel_d;
    logic             rd_q, rd_d;
    logic             clr_q, clr_d;

    logic [CH-1:0]    set_f;
    logic [CH-1:0]    svc;
    logic [NA-1:0]    out_nib;

    always_comb begin
        start_d    = start_q;
        end_d      = end_q;
        addr_d     = addr_q;
        loop_d     = loop_q;
        busy_d     = busy_q;
        reload_d   = reload_q;
        s_d        = s_q;
        slot_d     = slot_q;
        addr_out_d = addr_out_q;
        sel_d      = sel_q;
        rd_d       = rd_q;
        clr_d      = clr_q;
        set_f      = '0;
        svc        = '0;
        out_nib    = '0;

        for (int i = 0; i < CH; i++) begin
            if (int'(wr_ch) == i) begin
                if (wr_start) start_d[i] = wr_data;
                if (wr_end)   end_d[i]   = wr_data;
                if (wr_loop)  loop_d[i]  = wr_data[0];
            end
        end

        if (cen) begin
            slot_d = s_q;
            s_d    = (int'(s_q) == CH - 1) ? '0 : s_q + 1'b1;
            rd_d   = 1'b0;
            clr_d  = 1'b0;
            for (int i = 0; i < CH; i++) begin
                if (int'(s_q) == i) begin
                    svc[i] = 1'b1;
                    if (pend_off_q[i]) begin
                        busy_d[i]   = 1'b0;
                        reload_d[i] = 1'b0;
                    end else if (pend_on_q[i]) begin
                        out_nib     = {start_q[i], {SHIFT{1'b0}}};
                        addr_d[i]   = out_nib + 1'b1;
                        busy_d[i]   = 1'b1;
                        reload_d[i] = 1'b0;
                        rd_d        = 1'b1;
                        clr_d       = 1'b1;
                    end else if (busy_q[i]) begin
                        out_nib     = addr_q[i];
                        rd_d        = 1'b1;
                        clr_d       = reload_q[i];
                        reload_d[i] = 1'b0;
                        if (addr_q[i] == {end_q[i], {SHIFT{1'b1}}}) begin
                            set_f[i] = 1'b1;
                            if (loop_q[i]) begin
                                // restart the section; next visit tells the decoder
                                addr_d[i]   = {start_q[i], {SHIFT{1'b0}}};
                                reload_d[i] = 1'b1;
                            end else begin
                                busy_d[i] = 1'b0;
                            end
                        end else begin
                            addr_d[i] = addr_q[i] + 1'b1;
                        end
                    end
                end
            end
            if (rd_d) begin
                addr_out_d = out_nib[NA-1:1];
                sel_d      = out_nib[0];
            end
        end

        // an off request always overrides an on request in the same cycle
        pend_on_d  = ((pend_on_q & ~svc) | key_on) & ~key_off;
        pend_off_d = (pend_off_q & ~svc) | key_off;
        flags_d    = (flags_q & ~clr_flags) | set_f;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                addr_q[i]  <= '0;
            end
            loop_q     <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            busy_q     <= '0;
            flags_q    <= '0;
            reload_q   <= '0;
            s_q        <= '0;
            slot_q     <= '0;
            addr_out_q <= '0;
            sel_q      <= 1'b0;
            rd_q       <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                start_q[i] <= start_d[i];
                end_q[i]   <= end_d[i];
                addr_q[i]  <= addr_d[i];
            end
            loop_q     <= loop_d;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            busy_q     <= busy_d;
            flags_q    <= flags_d;
            reload_q   <= reload_d;
            s_q        <= s_d;
            slot_q     <= slot_d;
            addr_out_q <= addr_out_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            clr_q      <= clr_d;
        end
    end

    assign slot     = slot_q;
    assign addr_out = addr_out_q;
    assign sel      = sel_q;
    assign rd       = rd_q;
    assign clr      = clr_q;
    assign busy     = busy_q;
    assign flags    = flags_q;

endmodule
